// File: rtl/sdr_req_arbiter_n.sv
// N-channel ROM read arbiter onto a single SDRAM read port.
// Latches one request per channel, grants by fixed or round-robin priority, and can abort stalled reads.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no transaction outstanding; grant a pending slot if any
// ST_WAIT | sdr_req issued, waiting for sdr_rdy (or watchdog expiry)
`timescale 1ns/1ps
module sdr_req_arbiter_n #(
  parameter int CHANNELS = 4,
  parameter int AW       = 25,
  parameter int DW       = 16,
  parameter int RR_MODE  = 0,
  parameter int TIMEOUT  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CHANNELS-1:0]    rom_req,
  input  logic [CHANNELS*AW-1:0] rom_addr,
  output logic [DW-1:0]          rom_data,
  output logic [CHANNELS-1:0]    rom_rdy,
  output logic [CHANNELS-1:0]    overrun,
  output logic                   timeout,
  output logic                   busy,
  output logic [AW-1:0]          sdr_addr,
  output logic                   sdr_req,
  input  logic [DW-1:0]          sdr_data,
  input  logic                   sdr_rdy
);

  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]          state;
  logic [CHANNELS-1:0] req_d;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] req_edge;
  logic [CHANNELS-1:0] gnt;
  logic [AW-1:0]       slot [CHANNELS];
  logic [IW-1:0]       owner;
  logic [IW-1:0]       last;
  logic [IW-1:0]       win;
  logic                any_pend;
  logic [CW-1:0]       wd_cnt;
  logic [CW-1:0]       wd_inc;

  assign req_edge = rom_req & ~req_d;
  assign any_pend = |pending;
  assign busy     = (state == ST_WAIT);
  assign wd_inc   = wd_cnt + CW'(1);

  // Loops run from the far end so the last hit is the highest-priority one.
  always_comb begin
    int idx;
    win = '0;
    idx = 0;
    if (RR_MODE != 0) begin
      for (int k = CHANNELS; k >= 1; k--) begin
        idx = (int'(last) + k) % CHANNELS;
        if (pending[IW'(idx)]) win = IW'(idx);
      end
    end else begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (pending[i]) win = IW'(i);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (state == ST_IDLE && any_pend) gnt[win] = 1'b1;
  end

  // A slot only takes a new address when it is free or being granted this cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (req_edge[i] && (!pending[i] || gnt[i])) slot[i] <= rom_addr[i*AW +: AW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      req_d    <= '0;
      pending  <= '0;
      owner    <= '0;
      last     <= IW'(CHANNELS - 1);
      wd_cnt   <= '0;
      rom_data <= '0;
      rom_rdy  <= '0;
      overrun  <= '0;
      timeout  <= 1'b0;
      sdr_addr <= '0;
      sdr_req  <= 1'b0;
    end else begin
      req_d   <= rom_req;
      sdr_req <= 1'b0;
      rom_rdy <= '0;
      timeout <= 1'b0;
      overrun <= req_edge & pending & ~gnt;
      pending <= (pending & ~gnt) | req_edge;
      case (state)
        ST_IDLE: begin
          if (any_pend) begin
            sdr_addr <= slot[win];
            sdr_req  <= 1'b1;
            owner    <= win;
            last     <= win;
            wd_cnt   <= '0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sdr_rdy) begin
            rom_data       <= sdr_data;
            rom_rdy[owner] <= 1'b1;
            state          <= ST_IDLE;
          end else if (TIMEOUT > 0) begin
            if (wd_inc == CW'(TIMEOUT)) begin
              rom_data       <= '1;
              rom_rdy[owner] <= 1'b1;
              timeout        <= 1'b1;
              state          <= ST_IDLE;
            end else begin
              wd_cnt <= wd_inc;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_req_arbiter_n.sv
// Scoreboard bench for sdr_req_arbiter_n: a fixed-priority/watchdog instance and a round-robin instance share stimulus.
`timescale 1ns/1ps
module tb_sdr_req_arbiter_n;
  localparam int CH = 4;
  localparam int AW = 25;
  localparam int DW = 16;

  typedef struct {
    logic [1:0]    chan;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          to;
  } exp_t;

  exp_t sb[$];

  logic             clk = 1'b0;
  logic             reset;
  logic [CH-1:0]    rom_req;
  logic [CH*AW-1:0] rom_addr;
  logic [DW-1:0]    sdr_data;
  logic             sdr_rdy;
  logic             sel;

  logic [DW-1:0] f_rom_data, r_rom_data, rom_data;
  logic [CH-1:0] f_rom_rdy, r_rom_rdy, rom_rdy;
  logic [CH-1:0] f_overrun, r_overrun, overrun;
  logic          f_timeout, r_timeout, timeout;
  logic          f_busy, r_busy, busy;
  logic [AW-1:0] f_sdr_addr, r_sdr_addr, sdr_addr;
  logic          f_sdr_req, r_sdr_req, sdr_req;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_rdy   = 0;
  int n_issue = 0;
  int last_rdy_cyc = 0;
  int ovr_cnt [CH];

  int            resp_delay = 0;
  logic          no_resp = 1'b0;
  logic          resp_rdy = 1'b0;
  logic          man_rdy = 1'b0;
  logic [DW-1:0] resp_data = '0;
  logic          resp_armed = 1'b0;
  int            resp_cnt = 0;

  sdr_req_arbiter_n #(.CHANNELS(CH), .AW(AW), .DW(DW), .RR_MODE(0), .TIMEOUT(16)) u_fix (
    .clk(clk), .reset(reset), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_data(f_rom_data), .rom_rdy(f_rom_rdy), .overrun(f_overrun), .timeout(f_timeout),
    .busy(f_busy), .sdr_addr(f_sdr_addr), .sdr_req(f_sdr_req), .sdr_data(sdr_data), .sdr_rdy(sdr_rdy)
  );

  sdr_req_arbiter_n #(.CHANNELS(CH), .AW(AW), .DW(DW), .RR_MODE(1), .TIMEOUT(0)) u_rr (
    .clk(clk), .reset(reset), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_data(r_rom_data), .rom_rdy(r_rom_rdy), .overrun(r_overrun), .timeout(r_timeout),
    .busy(r_busy), .sdr_addr(r_sdr_addr), .sdr_req(r_sdr_req), .sdr_data(sdr_data), .sdr_rdy(sdr_rdy)
  );

  assign rom_data = sel ? r_rom_data : f_rom_data;
  assign rom_rdy  = sel ? r_rom_rdy  : f_rom_rdy;
  assign overrun  = sel ? r_overrun  : f_overrun;
  assign timeout  = sel ? r_timeout  : f_timeout;
  assign busy     = sel ? r_busy     : f_busy;
  assign sdr_addr = sel ? r_sdr_addr : f_sdr_addr;
  assign sdr_req  = sel ? r_sdr_req  : f_sdr_req;
  assign sdr_rdy  = resp_rdy | man_rdy;
  assign sdr_data = resp_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] f_data(logic [AW-1:0] a);
    return a[15:0] ^ 16'h9DAA;
  endfunction

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // SDRAM controller model: answers each sdr_req after resp_delay cycles.
  always @(negedge clk) begin
    resp_rdy = 1'b0;
    if (reset) begin
      resp_armed = 1'b0;
    end else if (sdr_req && !no_resp) begin
      resp_armed = 1'b1;
      resp_cnt   = resp_delay;
      resp_data  = f_data(sdr_addr);
    end
    if (resp_armed) begin
      if (resp_cnt == 0) begin
        resp_rdy   = 1'b1;
        resp_armed = 1'b0;
      end else begin
        resp_cnt--;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (sdr_req) begin
        n_issue++;
        if (sb.size() == 0) check_val("req_unexp", 32'(sb.size()), 32'd1);
        else check_val("sdr_addr", 32'(sdr_addr), 32'(sb[0].addr));
      end
      if (rom_rdy != '0) begin
        n_rdy++;
        last_rdy_cyc = cyc;
        if (sb.size() == 0) begin
          check_val("rdy_unexp", 32'(rom_rdy), 32'd0);
        end else begin
          e = sb.pop_front();
          check_val("rdy_chan", 32'(rom_rdy), 32'd1 << e.chan);
          check_val("rom_data", 32'(rom_data), 32'(e.data));
          check_val("timeout", 32'(timeout), 32'(e.to));
        end
      end else if (timeout) begin
        check_val("to_orphan", 32'(timeout), 32'd0);
      end
      for (int i = 0; i < CH; i++) if (overrun[i]) ovr_cnt[i]++;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_addr(int ch, logic [AW-1:0] a);
    rom_addr[ch*AW +: AW] = a;
  endtask

  task automatic push(int ch, logic [AW-1:0] a, logic [DW-1:0] d, logic to);
    exp_t e;
    e.chan = 2'(ch);
    e.addr = a;
    e.data = d;
    e.to   = to;
    sb.push_back(e);
  endtask

  task automatic pulse(logic [CH-1:0] m);
    rom_req = rom_req | m;
    tick();
    rom_req = rom_req & ~m;
  endtask

  task automatic wait_drain(int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check_val("drain", 32'(sb.size()), 32'd0);
    tick(2);
  endtask

  task automatic check_idle_outputs(string tag);
    check_val({tag, "_rom_data"}, 32'(rom_data), 32'd0);
    check_val({tag, "_rom_rdy"}, 32'(rom_rdy), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_sdr_req"}, 32'(sdr_req), 32'd0);
    check_val({tag, "_sdr_addr"}, 32'(sdr_addr), 32'd0);
    check_val({tag, "_overrun"}, 32'(overrun), 32'd0);
    check_val({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got cycle %0d expected end of run", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int c, base, r0, o1;
    logic [AW-1:0] rr1 [CH];
    logic [AW-1:0] rr2 [CH];
    for (int i = 0; i < CH; i++) ovr_cnt[i] = 0;
    reset = 1'b1; rom_req = '0; rom_addr = '0; sel = 1'b0;
    tick(3);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check_idle_outputs(s == 0 ? "rst_fix" : "rst_rr");
    end
    sel = 1'b0;
    reset = 1'b0;
    tick();

    // single request, minimum latency
    set_addr(2, 25'h0012345);
    push(2, 25'h0012345, 16'hBEEF, 1'b0);
    base = n_issue;
    c = cyc;
    pulse(4'b0100);
    wait_drain(50);
    check_val("lat_single", 32'(last_rdy_cyc), 32'(c + 3));
    check_val("issue_single", 32'(n_issue - base), 32'd1);

    // fixed priority: 3, 1, 0 together -> 0, 1, 3
    set_addr(0, 25'h0000F00);
    set_addr(1, 25'h0ABCDE1);
    set_addr(3, 25'h1000003);
    push(0, 25'h0000F00, f_data(25'h0000F00), 1'b0);
    push(1, 25'h0ABCDE1, f_data(25'h0ABCDE1), 1'b0);
    push(3, 25'h1000003, f_data(25'h1000003), 1'b0);
    base = n_issue;
    pulse(4'b1011);
    wait_drain(80);
    check_val("issue_fixed", 32'(n_issue - base), 32'd3);

    // overrun: second edge on a pending, ungranted channel is dropped
    resp_delay = 3;
    set_addr(0, 25'h0111110);
    set_addr(1, 25'h0222220);
    push(0, 25'h0111110, f_data(25'h0111110), 1'b0);
    push(1, 25'h0222220, f_data(25'h0222220), 1'b0);
    o1 = ovr_cnt[1];
    base = n_issue;
    pulse(4'b0011);
    set_addr(1, 25'h0333330);
    tick();
    pulse(4'b0010);
    wait_drain(80);
    check_val("ovr_pulse", 32'(ovr_cnt[1] - o1), 32'd1);
    check_val("issue_ovr", 32'(n_issue - base), 32'd2);

    // edge in the grant cycle is queued behind the granted old address
    resp_delay = 0;
    set_addr(0, 25'h0444440);
    set_addr(1, 25'h0555550);
    push(0, 25'h0444440, f_data(25'h0444440), 1'b0);
    push(1, 25'h0555550, f_data(25'h0555550), 1'b0);
    push(1, 25'h0666660, f_data(25'h0666660), 1'b0);
    o1 = ovr_cnt[1];
    base = n_issue;
    pulse(4'b0011);
    tick(2);
    set_addr(1, 25'h0666660);
    pulse(4'b0010);
    wait_drain(80);
    check_val("ovr_none", 32'(ovr_cnt[1] - o1), 32'd0);
    check_val("issue_queue", 32'(n_issue - base), 32'd3);

    // watchdog: no sdr_rdy -> abort after 16 WAIT cycles
    no_resp = 1'b1;
    set_addr(2, 25'h0777770);
    push(2, 25'h0777770, 16'hFFFF, 1'b1);
    base = n_issue;
    c = cyc;
    pulse(4'b0100);
    wait_drain(60);
    check_val("lat_wd", 32'(last_rdy_cyc), 32'(c + 18));
    check_val("issue_wd", 32'(n_issue - base), 32'd1);
    check_val("busy_after_wd", 32'(busy), 32'd0);
    r0 = n_rdy;
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
    tick(3);
    check_val("late_rdy", 32'(n_rdy - r0), 32'd0);

    // reset during WAIT, held requests serviced after release
    set_addr(0, 25'h0888880);
    set_addr(2, 25'h0999990);
    push(0, 25'h0888880, f_data(25'h0888880), 1'b0);
    push(2, 25'h0999990, f_data(25'h0999990), 1'b0);
    r0 = n_rdy;
    rom_req = 4'b0101;
    tick(2);
    check_val("busy_wait", 32'(busy), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check_idle_outputs("rst_wait");
    check_val("rst_no_rdy", 32'(n_rdy - r0), 32'd0);
    reset = 1'b0;
    man_rdy = 1'b1;
    no_resp = 1'b0;
    tick();
    man_rdy = 1'b0;
    wait_drain(80);
    check_val("rst_serviced", 32'(n_rdy - r0), 32'd2);
    rom_req = '0;
    tick(2);

    // round-robin instance: re-request after each completion
    sel = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
    resp_delay = 1;
    for (int i = 0; i < CH; i++) begin
      rr1[i] = 25'h0A00000 + 25'(i * 16);
      rr2[i] = 25'h0B00000 + 25'(i * 16);
      set_addr(i, rr1[i]);
    end
    for (int i = 0; i < CH; i++) push(i, rr1[i], f_data(rr1[i]), 1'b0);
    for (int i = 0; i < CH; i++) push(i, rr2[i], f_data(rr2[i]), 1'b0);
    r0 = n_rdy;
    pulse(4'b1111);
    for (int k = 0; k < CH; k++) begin
      for (int t = 0; t < 40 && n_rdy < r0 + k + 1; t++) tick();
      check_val("rr_done", 32'(n_rdy >= r0 + k + 1), 32'd1);
      set_addr(k, rr2[k]);
      pulse(CH'(1) << k);
    end
    wait_drain(120);
    check_val("rr_count", 32'(n_rdy - r0), 32'd8);

    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
